mult_unit: RTL and testbench
============================

// Module: mult_unit
// PURPOSE
//   Sequential signed radix-2 Booth multiplier for MULT, sitting beside the ALU in the multicycle datapath.
//   Started by control_unit.mult_init with operands from the A/B registers.
//   Produces the 64-bit product {hi_out, lo_out} for the HI/LO registers.
//   Returns mult_stop so control_unit can leave its MULT wait state and pulse high_load/low_load.
// PARAMETERS
//   WIDTH  32  operand width; product is 2*WIDTH bits, iteration count = WIDTH
// PORTS
//   clk        in   1      system clock, rising edge
//   reset_in   in   1      asynchronous, active-low reset (0 = reset)
//   mult_init  in   1      start request from control unit; sampled only in IDLE
//   a_in       in   WIDTH  multiplicand (signed, two's complement)
//   b_in       in   WIDTH  multiplier (signed, two's complement)
//   hi_out     out  WIDTH  upper half of product, registered
//   lo_out     out  WIDTH  lower half of product, registered
//   mult_stop  out  1      result-valid pulse, exactly one cycle wide
//   busy       out  1      high while state != IDLE
// BEHAVIOUR
//   Reset (reset_in=0, async):
//     - state=IDLE; all internal regs cleared.
//     - hi_out=0, lo_out=0, mult_stop=0, busy=0.
//   Internal regs: M (WIDTH), Acc (WIDTH+1, sign-extended), Q (WIDTH), q_m1 (1), cnt (clog2(WIDTH)+1).
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     - On edge with mult_init=1: M<=a_in, Acc<=0, Q<=b_in, q_m1<=0, cnt<=WIDTH; go RUN.
//     - Operands are captured at this edge; later a_in/b_in changes are ignored.
//   RUN, each edge:
//     - {Q[0],q_m1}: 01 -> Acc+=sext(M); 10 -> Acc-=sext(M); 00/11 -> no change.
//     - Then arithmetic-shift-right {Acc,Q,q_m1} by 1; cnt<=cnt-1.
//     - When the step with cnt==1 completes: hi_out<=Acc[WIDTH-1:0], lo_out<=Q; go DONE.
//   DONE: mult_stop=1 (Moore output of state); next edge -> IDLE.
//   Latency: mult_init sampled at edge k -> hi/lo update at edge k+WIDTH -> mult_stop high in the cycle after that edge.
//     - Default WIDTH: mult_stop high 33 cycles after mult_init is sampled.
//   Acc is WIDTH+1 bits, so M = -2^(WIDTH-1) is handled without overflow; result is exact for all operand pairs.
//   hi_out/lo_out hold the last result until the next DONE; they are never cleared except by reset.
//   mult_init while busy: ignored; no restart, no queueing.
//   mult_init high in DONE: ignored; a new op needs mult_init in IDLE (earliest: the cycle after mult_stop).
//   Reset mid-operation (RUN or DONE): immediate abort to the reset values above; no mult_stop pulse.
// CONFIGURATION
//   MULT_ZERO_BYPASS_EN
//     Defined: in IDLE, if mult_init=1 and (a_in==0 or b_in==0):
//       - hi_out<=0, lo_out<=0, go directly to DONE.
//       - mult_stop is high in the cycle after the init edge (latency 1).
//       - Other operands are unaffected.
//     Undefined: zero operands take the full WIDTH+1 cycle path; the result is identical.
// TESTING
//   1. a=7, b=6, 1-cycle mult_init -> hi=0x00000000, lo=0x0000002A; mult_stop 1 cycle wide, 33 cycles after init edge; busy high throughout.
//   2. a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//   3. a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
//   4. Start 7*6, pulse mult_init with a=b=2 at cycle 10 of RUN -> result still 42, only one mult_stop.
//      Then 2*2 started after the pulse -> lo=4.
//   5. reset_in=0 at cycle 12 of RUN -> hi/lo/busy/mult_stop=0 immediately, no stop pulse.
//      Then 9*9 after release -> lo=81.
//   6. a=0, b=12345: with MULT_ZERO_BYPASS_EN -> mult_stop 1 cycle after init, hi=lo=0.
//      Without the macro -> mult_stop after 33 cycles, hi=lo=0.

Source files
------------

// File: rtl/mult_unit_if.sv
// ============================================================================
// Module  : mult_unit_if
// Purpose : Start/operand/result bundle between the control unit and mult_unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult_init;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             mult_stop;
    logic             busy;

    modport master (
        output mult_init, a_in, b_in,
        input  hi_out, lo_out, mult_stop, busy
    );

    modport slave (
        input  mult_init, a_in, b_in,
        output hi_out, lo_out, mult_stop, busy
    );
endinterface

`default_nettype wire

// File: rtl/mult_unit.sv
// ============================================================================
// Module  : mult_unit
// Purpose : Sequential signed radix-2 Booth multiplier producing {hi,lo}.
//           Optional MULT_ZERO_BYPASS_EN: zero operand finishes in one cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     reset_in,
    mult_unit_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH:0]     acc_shift;
    logic [WIDTH-1:0]   q_shift;

    // Acc is one bit wider than M so that subtracting -2^(WIDTH-1) cannot overflow.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + m_ext;
            2'b10:   acc_sum = acc_q - m_ext;
            default: acc_sum = acc_q;
        endcase
        acc_shift = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        q_shift   = {acc_sum[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mult_init) begin
`ifdef MULT_ZERO_BYPASS_EN
                    if ((bus.a_in == '0) || (bus.b_in == '0)) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        m_d     = bus.a_in;
                        acc_d   = '0;
                        q_d     = bus.b_in;
                        qm1_d   = 1'b0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_RUN;
                    end
`else
                    m_d     = bus.a_in;
                    acc_d   = '0;
                    q_d     = bus.b_in;
                    qm1_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                acc_d = acc_shift;
                q_d   = q_shift;
                qm1_d = q_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = acc_shift[WIDTH-1:0];
                    lo_d    = q_shift;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;
    assign bus.mult_stop = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
// ============================================================================
// Module  : tb_mult_unit
// Purpose : Directed self-checking bench for mult_unit (WIDTH=32).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_unit;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 100;

    logic clk;
    logic reset_in;
    int   checks;
    int   errors;

    mult_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation from IDLE; lat = edges after the init edge until mult_stop is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit busy_ok, output bit stop_fell);
        @(posedge clk); #1;
        bus.mult_init = 1'b1;
        bus.a_in      = a;
        bus.b_in      = b;
        @(posedge clk); #1;
        bus.mult_init = 1'b0;
        bus.a_in      = 32'hDEAD_BEEF;
        bus.b_in      = 32'h1234_5678;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.mult_stop && lat < TIMEOUT) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        stop_fell = !bus.mult_stop && !bus.busy;
    endtask

    task automatic test_reset();
        bus.mult_init = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        reset_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (bus.mult_stop !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: stop=%b busy=%b expected 0 0", bus.mult_stop, bus.busy);
        end
        reset_in = 1'b1;
    endtask

    task automatic test_basic();
        int lat; bit bo; bit sf;
        do_op(32'd7, 32'd6, lat, bo, sf);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 32", lat);
        end
        checks++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h2A) begin
            errors++;
            $display("FAIL basic_result: got %h_%h expected 00000000_0000002a", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (!bo) begin
            errors++;
            $display("FAIL basic_busy: busy dropped during operation, expected high");
        end
        checks++;
        if (!sf) begin
            errors++;
            $display("FAIL basic_stop_width: stop/busy still high after one cycle, expected low");
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.lo_out !== 32'h2A) begin
            errors++;
            $display("FAIL basic_hold: got lo=%h expected 0000002a", bus.lo_out);
        end
    endtask

    task automatic test_signed();
        int lat; bit bo; bit sf;
        do_op(32'hFFFF_FFFD, 32'd5, lat, bo, sf);
        checks++;
        if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL signed_neg3x5: got %h_%h expected ffffffff_fffffff1", bus.hi_out, bus.lo_out);
        end
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bo, sf);
        checks++;
        if (bus.hi_out !== 32'h3FFF_FFFF || bus.lo_out !== 32'h0000_0001) begin
            errors++;
            $display("FAIL signed_maxpos: got %h_%h expected 3fffffff_00000001", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_minint();
        int lat; bit bo; bit sf;
        do_op(32'h8000_0000, 32'h8000_0000, lat, bo, sf);
        checks++;
        if (bus.hi_out !== 32'h4000_0000 || bus.lo_out !== 32'h0) begin
            errors++;
            $display("FAIL minint_sq: got %h_%h expected 40000000_00000000", bus.hi_out, bus.lo_out);
        end
        do_op(32'h8000_0000, 32'd1, lat, bo, sf);
        checks++;
        if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'h8000_0000) begin
            errors++;
            $display("FAIL minint_x1: got %h_%h expected ffffffff_80000000", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_init_while_busy();
        int pulses; int lat; bit bo; bit sf;
        @(posedge clk); #1;
        bus.mult_init = 1'b1;
        bus.a_in      = 32'd7;
        bus.b_in      = 32'd6;
        @(posedge clk); #1;
        bus.mult_init = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 45; i++) begin
            bus.mult_init = (i == 10);
            bus.a_in      = (i == 10) ? 32'd2 : 32'd0;
            bus.b_in      = (i == 10) ? 32'd2 : 32'd0;
            @(posedge clk); #1;
            if (bus.mult_stop) pulses++;
        end
        bus.mult_init = 1'b0;
        checks++;
        if (bus.lo_out !== 32'd42 || bus.hi_out !== 32'd0) begin
            errors++;
            $display("FAIL busy_init_result: got %h_%h expected 00000000_0000002a", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL busy_init_pulses: got %0d expected 1", pulses);
        end
        do_op(32'd2, 32'd2, lat, bo, sf);
        checks++;
        if (bus.lo_out !== 32'd4 || bus.hi_out !== 32'd0) begin
            errors++;
            $display("FAIL busy_init_followup: got %h_%h expected 00000000_00000004", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses; int lat; bit bo; bit sf;
        @(posedge clk); #1;
        bus.mult_init = 1'b1;
        bus.a_in      = 32'd5;
        bus.b_in      = 32'd5;
        @(posedge clk); #1;
        bus.mult_init = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        reset_in = 1'b0;
        #1;
        checks++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || bus.busy !== 1'b0 || bus.mult_stop !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got hi=%h lo=%h busy=%b stop=%b expected all 0",
                     bus.hi_out, bus.lo_out, bus.busy, bus.mult_stop);
        end
        @(posedge clk); #1;
        reset_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.mult_stop) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midreset_nostop: got %0d pulses expected 0", pulses);
        end
        do_op(32'd9, 32'd9, lat, bo, sf);
        checks++;
        if (bus.lo_out !== 32'd81 || bus.hi_out !== 32'd0) begin
            errors++;
            $display("FAIL midreset_followup: got %h_%h expected 00000000_00000051", bus.hi_out, bus.lo_out);
        end
    endtask

    task automatic test_zero_operand();
        int lat; int exp_lat; bit bo; bit sf;
`ifdef MULT_ZERO_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 32;
`endif
        do_op(32'd0, 32'd12345, lat, bo, sf);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected %0d", lat, exp_lat);
        end
        checks++;
        if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
            errors++;
            $display("FAIL zero_result: got %h_%h expected 0", bus.hi_out, bus.lo_out);
        end
        checks++;
        if (!sf) begin
            errors++;
            $display("FAIL zero_stop_width: stop/busy still high after one cycle, expected low");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signed();
        test_minint();
        test_init_while_busy();
        test_reset_mid_run();
        test_zero_operand();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
